// File: rtl/video_pattern_generator.sv
// rtl/video_pattern_generator.sv - VGA test-pattern generator with debounced mode button
//
// Produces registered per-pixel RGB from the timing block's column/row counters.
// Output latency is one clock, and the output is blanked outside the active area.
// The mode button selects one of 8 patterns: 4 solid colours, colour bars,
// checkerboard, red gradient and border.
//
// Optional build macro: VIDEO_PATTERN_AUTO_CYCLE_EN
//   When defined, the mode also advances automatically every AUTO_FRAMES frames.
//
// Ports:
//   clk          in   pixel clock
//   rst          in   asynchronous reset, active-high
//   btn          in   raw mode button (asynchronous, bouncy, active-high)
//   col_counter  in   current column  [CNT_W]
//   row_counter  in   current row     [CNT_W]
//   red          out  red drive       [RED_W], registered
//   grn          out  green drive     [GRN_W], registered
//   blu          out  blue drive      [BLU_W], registered
//   mode         out  current pattern index [3], registered
module video_pattern_generator #(
  parameter int DISP_COLS       = 640,
  parameter int DISP_ROWS       = 480,
  parameter int CNT_W           = 12,
  parameter int RED_W           = 3,
  parameter int GRN_W           = 3,
  parameter int BLU_W           = 2,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int CHECKER_LOG2    = 5,
  parameter int GRAD_SHIFT      = 7,
  parameter int AUTO_FRAMES     = 60
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn,
  input  logic [CNT_W-1:0] col_counter,
  input  logic [CNT_W-1:0] row_counter,
  output logic [RED_W-1:0] red,
  output logic [GRN_W-1:0] grn,
  output logic [BLU_W-1:0] blu,
  output logic [2:0]       mode
);

  localparam int                DB_W   = $clog2(DEBOUNCE_CYCLES);
  localparam logic [DB_W-1:0]   DB_MAX = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [RED_W-1:0]  R_FULL = '1;
  localparam logic [GRN_W-1:0]  G_FULL = '1;
  localparam logic [BLU_W-1:0]  B_FULL = '1;

  // Button synchroniser and debouncer
  logic            btn_m, btn_s;
  logic            deb, deb_d;
  logic [DB_W-1:0] deb_cnt;
  logic            btn_adv;
  logic            step;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_m   <= 1'b0;
      btn_s   <= 1'b0;
      deb     <= 1'b0;
      deb_d   <= 1'b0;
      deb_cnt <= '0;
    end else begin
      btn_m <= btn;
      btn_s <= btn_m;
      deb_d <= deb;
      if (btn_s == deb) begin
        deb_cnt <= '0;
      end else if (deb_cnt == DB_MAX) begin
        deb     <= btn_s;
        deb_cnt <= '0;
      end else begin
        deb_cnt <= deb_cnt + 1'b1;
      end
    end
  end

  // Only the press edge advances; holding or releasing does not.
  assign btn_adv = deb & ~deb_d;

`ifdef VIDEO_PATTERN_AUTO_CYCLE_EN
  localparam int               FR_W   = $clog2(AUTO_FRAMES) + 1;
  localparam logic [FR_W-1:0]  FR_MAX = FR_W'(AUTO_FRAMES - 1);

  logic [FR_W-1:0] frame_cnt;
  logic            frame_evt;
  logic            auto_adv;

  assign frame_evt = (col_counter == '0) && (row_counter == '0);
  assign auto_adv  = frame_evt && (frame_cnt == FR_MAX);
  // A coincident button and auto advance collapse into a single step.
  assign step      = btn_adv | auto_adv;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_cnt <= '0;
    end else if (btn_adv || auto_adv) begin
      frame_cnt <= '0;
    end else if (frame_evt) begin
      frame_cnt <= frame_cnt + 1'b1;
    end
  end
`else
  assign step = btn_adv;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode <= 3'd0;
    end else if (step) begin
      mode <= mode + 3'd1;
    end
  end

  // Pixel generation
  logic             active;
  logic [2:0]       bar;
  logic [2:0]       bar_c;
  logic             border;
  logic [RED_W-1:0] r_n;
  logic [GRN_W-1:0] g_n;
  logic [BLU_W-1:0] b_n;

  assign active = (col_counter < CNT_W'(DISP_COLS)) && (row_counter < CNT_W'(DISP_ROWS));
  assign border = (col_counter == '0) || (col_counter == CNT_W'(DISP_COLS - 1)) ||
                  (row_counter == '0) || (row_counter == CNT_W'(DISP_ROWS - 1));

  // Bar index from constant boundaries k*DISP_COLS/8; no runtime divide.
  always_comb begin
    bar = 3'd0;
    for (int i = 1; i < 8; i++) begin
      if (col_counter >= CNT_W'(i * DISP_COLS / 8)) bar = 3'(i);
    end
  end

  assign bar_c = 3'd7 - bar;

  always_comb begin
    r_n = '0;
    g_n = '0;
    b_n = '0;
    if (active) begin
      case (mode)
        3'd0: begin r_n = R_FULL; g_n = G_FULL; end
        3'd1: begin r_n = R_FULL; b_n = B_FULL; end
        3'd2: begin g_n = G_FULL; b_n = B_FULL; end
        3'd3: begin r_n = R_FULL; g_n = G_FULL; b_n = B_FULL; end
        3'd4: begin
          r_n = bar_c[2] ? R_FULL : '0;
          g_n = bar_c[1] ? G_FULL : '0;
          b_n = bar_c[0] ? B_FULL : '0;
        end
        3'd5: begin
          if (!(col_counter[CHECKER_LOG2] ^ row_counter[CHECKER_LOG2])) begin
            r_n = R_FULL; g_n = G_FULL; b_n = B_FULL;
          end
        end
        3'd6: r_n = col_counter[GRAD_SHIFT +: RED_W];
        default: begin
          if (border) begin
            r_n = R_FULL; g_n = G_FULL; b_n = B_FULL;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      red <= '0;
      grn <= '0;
      blu <= '0;
    end else begin
      red <= r_n;
      grn <= g_n;
      blu <= b_n;
    end
  end

endmodule

// File: tb/tb_video_pattern_generator.sv
// tb/tb_video_pattern_generator.sv - self-checking bench for video_pattern_generator
module tb_video_pattern_generator;

  localparam int IDLE = 700;

  logic        clk = 1'b0;
  logic        rst;
  logic        btn;
  logic [11:0] col;
  logic [11:0] row;
  logic [2:0]  red;
  logic [2:0]  grn;
  logic [1:0]  blu;
  logic [2:0]  mode;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string      tag;
    logic [7:0] rgb;
  } exp_t;

  exp_t exp_q[$];

  video_pattern_generator #(
    .DISP_COLS(640), .DISP_ROWS(480), .CNT_W(12),
    .RED_W(3), .GRN_W(3), .BLU_W(2),
    .DEBOUNCE_CYCLES(4), .CHECKER_LOG2(5), .GRAD_SHIFT(7), .AUTO_FRAMES(2)
  ) dut (
    .clk(clk), .rst(rst), .btn(btn),
    .col_counter(col), .row_counter(row),
    .red(red), .grn(grn), .blu(blu), .mode(mode)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one pixel, queue its expected colour, compare one clock later.
  task automatic pix(input string tag, input int c, input int r,
                     input logic [2:0] er, input logic [2:0] eg, input logic [1:0] eb);
    exp_t e;
    @(negedge clk);
    col = 12'(c);
    row = 12'(r);
    e.tag = tag;
    e.rgb = {er, eg, eb};
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk(e.tag, {24'd0, red, grn, blu}, {24'd0, e.rgb});
    col = 12'(IDLE);
    row = 12'(IDLE);
  endtask

  task automatic press();
    @(negedge clk);
    btn = 1'b1;
    repeat (12) @(negedge clk);
    btn = 1'b0;
    repeat (12) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic frame_event();
    @(negedge clk);
    col = 12'd0;
    row = 12'd0;
    @(negedge clk);
    col = 12'(IDLE);
    row = 12'(IDLE);
    @(negedge clk);
  endtask

  initial begin
    int         ones;
    logic [2:0] bc;
    rst = 1'b1;
    btn = 1'b0;
    col = 12'(IDLE);
    row = 12'(IDLE);
    repeat (3) @(negedge clk);
    chk("reset_rgb", {24'd0, red, grn, blu}, 32'd0);
    chk("reset_mode", {29'd0, mode}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

`ifndef VIDEO_PATTERN_AUTO_CYCLE_EN
    // Bouncy press: exactly one advance, no repeat on hold, none on release.
    @(negedge clk); btn = 1'b1;
    @(negedge clk); btn = 1'b0;
    @(negedge clk); btn = 1'b1;
    @(negedge clk); btn = 1'b0;
    @(negedge clk); btn = 1'b1;
    repeat (10) @(negedge clk);
    chk("bounce_adv", {29'd0, mode}, 32'd1);
    repeat (100) @(negedge clk);
    chk("hold_no_repeat", {29'd0, mode}, 32'd1);
    btn = 1'b0;
    repeat (20) @(negedge clk);
    chk("release_no_adv", {29'd0, mode}, 32'd1);

    // Reach mode 3, then reset mid-frame.
    press();
    press();
    chk("mode3", {29'd0, mode}, 32'd3);
    pix("white_10_10", 10, 10, 3'd7, 3'd7, 2'd3);
    @(negedge clk);
    col = 12'd10;
    row = 12'd10;
    @(posedge clk);
    #2;
    chk("pre_rst_rgb", {24'd0, red, grn, blu}, 32'hFF);
    rst = 1'b1;
    #1;
    chk("async_rst_rgb", {24'd0, red, grn, blu}, 32'd0);
    chk("async_rst_mode", {29'd0, mode}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    col = 12'(IDLE);
    row = 12'(IDLE);
    pix("yellow_after_rst", 10, 10, 3'd7, 3'd7, 2'd0);

    // Eight clean presses walk 1..7 then wrap to 0.
    for (int i = 1; i <= 8; i++) begin
      press();
      chk($sformatf("press_seq_%0d", i), {29'd0, mode}, 32'(i % 8));
    end

    pix("blank_col640", 640, 10, 3'd0, 3'd0, 2'd0);
    pix("blank_row480", 10, 480, 3'd0, 3'd0, 2'd0);
    pix("active_col639", 639, 479, 3'd7, 3'd7, 2'd0);

    repeat (4) press();
    chk("mode4", {29'd0, mode}, 32'd4);
    for (int k = 0; k < 8; k++) begin
      bc = 3'(7 - k);
      pix($sformatf("bar%0d_lo", k), k * 80, 0,
          bc[2] ? 3'd7 : 3'd0, bc[1] ? 3'd7 : 3'd0, bc[0] ? 2'd3 : 2'd0);
      pix($sformatf("bar%0d_hi", k), k * 80 + 79, 0,
          bc[2] ? 3'd7 : 3'd0, bc[1] ? 3'd7 : 3'd0, bc[0] ? 2'd3 : 2'd0);
    end
    pix("bar_blank640", 640, 0, 3'd0, 3'd0, 2'd0);

    press();
    chk("mode5", {29'd0, mode}, 32'd5);
    pix("chk_0_0", 0, 0, 3'd7, 3'd7, 2'd3);
    pix("chk_32_0", 32, 0, 3'd0, 3'd0, 2'd0);
    pix("chk_32_32", 32, 32, 3'd7, 3'd7, 2'd3);
    pix("chk_0_32", 0, 32, 3'd0, 3'd0, 2'd0);

    press();
    chk("mode6", {29'd0, mode}, 32'd6);
    pix("grad_0", 0, 5, 3'd0, 3'd0, 2'd0);
    pix("grad_128", 128, 5, 3'd1, 3'd0, 2'd0);
    pix("grad_639", 639, 5, 3'd4, 3'd0, 2'd0);

    press();
    chk("mode7", {29'd0, mode}, 32'd7);
    pix("brd_0_200", 0, 200, 3'd7, 3'd7, 2'd3);
    pix("brd_1_200", 1, 200, 3'd0, 3'd0, 2'd0);
    pix("brd_639_479", 639, 479, 3'd7, 3'd7, 2'd3);
    pix("brd_640_479", 640, 479, 3'd0, 3'd0, 2'd0);
    pix("brd_300_0", 300, 0, 3'd7, 3'd7, 2'd3);
`else
    // Auto advance every 2nd frame start.
    frame_event();
    chk("auto_ev1", {29'd0, mode}, 32'd0);
    frame_event();
    chk("auto_ev2", {29'd0, mode}, 32'd1);
    frame_event();
    chk("auto_ev3", {29'd0, mode}, 32'd1);
    frame_event();
    chk("auto_ev4", {29'd0, mode}, 32'd2);

    // Sweep a frame start across a press. Only the offset that lands on the
    // button advance merges both into one step and clears the frame count,
    // leaving mode 1 after a trailing frame start; every other offset gives 2.
    ones = 0;
    for (int d = 0; d < 16; d++) begin
      do_reset();
      frame_event();
      @(negedge clk);
      btn = 1'b1;
      for (int t = 0; t < 20; t++) begin
        col = (t == d) ? 12'd0 : 12'(IDLE);
        row = (t == d) ? 12'd0 : 12'(IDLE);
        @(negedge clk);
      end
      col = 12'(IDLE);
      row = 12'(IDLE);
      btn = 1'b0;
      repeat (12) @(negedge clk);
      frame_event();
      chk($sformatf("auto_off%0d_range", d), {31'd0, (mode == 3'd1) || (mode == 3'd2)}, 32'd1);
      if (mode == 3'd1) ones++;
    end
    chk("auto_coincident_single", 32'(ones), 32'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
